clock_set_ctrl: RTL

Controller that sequences the 6-digit BCD time-of-day counter.
- Run mode: generates the 1 Hz count-enable tick from the system clock.
- Set mode: freezes counting and walks a one-hot digit selection from hours-tens down to seconds-units. Each increment button press issues a single-cycle count pulse to the selected digit.
- Sits between the debounced front-panel buttons and the counter's update_*/cnt_en inputs. Also drives the display blink.

---
 rtl/clock_set_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
//   Sequencer for a 6-digit BCD time-of-day counter. In run mode it divides
//   the system clock down to a one-cycle-per-second count enable. In set mode
//   it freezes counting, walks a one-hot digit select from hours-tens to
//   seconds-units on each mode button edge, and turns each increment button
//   edge into a single-cycle update_count pulse. A set-mode inactivity
//   timeout returns to run mode. It also drives the display blink.
//
// Parameters
//   TICK_DIV   clock cycles per second tick (>= 4, even)
//   TIMEOUT_S  seconds of set-mode inactivity before returning to run (0 = off)
//
// Optional feature macro: CLOCK_SET_AUTO_REPEAT_EN
//   When defined, holding inc_btn in a set state auto-repeats update_count:
//   first repeat TICK_DIV/2 cycles after the edge pulse, then every
//   TICK_DIV/4 cycles while held. Undefined: one pulse per edge only.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mode_btn        debounced mode button level
//   inc_btn         debounced increment button level
//   cnt_en          one-cycle second tick to the counter (run mode only)
//   update_H2..S1   registered one-hot digit select (all 0 in run mode)
//   update_count    one-cycle increment pulse to the selected digit
//   setting         high in any set state
//   blink           display show(1)/blank(0) for the selected digit
//   dbg_state       current FSM state encoding
//
// Handshake: none. Buttons are level inputs; each rising level (btn & ~prev)
// is one event. Outputs are pulses/levels consumed without back-pressure.
// ---------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic       cnt_en,
  output logic       update_H2,
  output logic       update_H1,
  output logic       update_M2,
  output logic       update_M1,
  output logic       update_S2,
  output logic       update_S1,
  output logic       update_count,
  output logic       setting,
  output logic       blink,
  output logic [2:0] dbg_state
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int TO_W  = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(TICK_DIV / 2);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_S);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_SET_H2 = 3'd1,
    S_SET_H1 = 3'd2,
    S_SET_M2 = 3'd3,
    S_SET_M1 = 3'd4,
    S_SET_S2 = 3'd5,
    S_SET_S1 = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             mode_prev_q, inc_prev_q;
  logic [5:0]       upd_q, upd_d;      // {H2,H1,M2,M1,S2,S1}
  logic             upd_cnt_q, upd_cnt_d;
  logic             setting_q, setting_d;

  logic mode_edge, inc_edge, in_set, wrap, timeout_hit, enter_run, rep_fire;

  assign mode_edge   = mode_btn & ~mode_prev_q;
  assign inc_edge    = inc_btn & ~inc_prev_q;
  assign in_set      = (state_q != S_RUN);
  assign wrap        = (pre_q == PRE_MAX);
  assign timeout_hit = in_set && (TIMEOUT_S != 0) && (to_q == TO_MAX);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam logic [PRE_W-1:0] REP_FIRST = PRE_W'(TICK_DIV / 2 - 1);
  localparam logic [PRE_W-1:0] REP_NEXT  = PRE_W'(TICK_DIV / 4 - 1);

  logic [PRE_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_act_q, rep_act_d;

  // rep_cnt counts held cycles since the edge (or since the last repeat).
  // Any disturbance -- release, new edge, state change -- restarts it.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_act_d = rep_act_q;
    rep_fire  = 1'b0;
    if (!in_set || !inc_btn || inc_edge || mode_edge || timeout_hit) begin
      rep_cnt_d = '0;
      rep_act_d = 1'b0;
    end else if (!rep_act_q) begin
      if (rep_cnt_q == REP_FIRST) begin
        rep_fire  = 1'b1;
        rep_act_d = 1'b1;
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + PRE_W'(1);
      end
    end else begin
      if (rep_cnt_q == REP_NEXT) begin
        rep_fire  = 1'b1;
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_act_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_act_q <= rep_act_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Next state: timeout beats a mode edge, a mode edge beats an inc event.
  always_comb begin
    state_d   = state_q;
    upd_cnt_d = 1'b0;
    if (timeout_hit) begin
      state_d = S_RUN;
    end else if (mode_edge) begin
      case (state_q)
        S_RUN:    state_d = S_SET_H2;
        S_SET_H2: state_d = S_SET_H1;
        S_SET_H1: state_d = S_SET_M2;
        S_SET_M2: state_d = S_SET_M1;
        S_SET_M1: state_d = S_SET_S2;
        S_SET_S2: state_d = S_SET_S1;
        default:  state_d = S_RUN;
      endcase
    end else if (in_set && (inc_edge || rep_fire)) begin
      upd_cnt_d = 1'b1;
    end
  end

  assign enter_run = in_set && (state_d == S_RUN);

  // Prescaler restarts on run entry so the first second is a full one.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (enter_run || wrap) pre_d = '0;
  end

  always_comb begin
    to_d = to_q;
    if (!in_set || enter_run || mode_edge || inc_edge || rep_fire) begin
      to_d = '0;
    end else if (wrap && (TIMEOUT_S != 0) && (to_q != TO_MAX)) begin
      to_d = to_q + TO_W'(1);
    end
  end

  always_comb begin
    upd_d = 6'b000000;
    case (state_d)
      S_SET_H2: upd_d = 6'b100000;
      S_SET_H1: upd_d = 6'b010000;
      S_SET_M2: upd_d = 6'b001000;
      S_SET_M1: upd_d = 6'b000100;
      S_SET_S2: upd_d = 6'b000010;
      S_SET_S1: upd_d = 6'b000001;
      default:  upd_d = 6'b000000;
    endcase
    setting_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pre_q       <= '0;
      to_q        <= '0;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      upd_q       <= 6'b000000;
      upd_cnt_q   <= 1'b0;
      setting_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      to_q        <= to_d;
      mode_prev_q <= mode_btn;
      inc_prev_q  <= inc_btn;
      upd_q       <= upd_d;
      upd_cnt_q   <= upd_cnt_d;
      setting_q   <= setting_d;
    end
  end

  assign cnt_en       = !in_set && wrap;
  assign update_H2    = upd_q[5];
  assign update_H1    = upd_q[4];
  assign update_M2    = upd_q[3];
  assign update_M1    = upd_q[2];
  assign update_S2    = upd_q[1];
  assign update_S1    = upd_q[0];
  assign update_count = upd_cnt_q;
  assign setting      = setting_q;
  // Shown during the first half-second and whenever a digit is being bumped.
  assign blink        = !in_set || upd_cnt_q || (pre_q < PRE_HALF);
  assign dbg_state    = state_q;

endmodule
